// File: rtl/i2c_target.sv
// i2c_target: I2C target with fixed 7-bit address, write delivery and read request/valid handshake.
// Optional SCL clock stretching on missing read data is enabled by defining I2C_TARGET_STRETCH_EN.
module i2c_target #(
  parameter int DATA_WIDTH = 8,
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic SCL_IN,
  input  logic SDA_IN,
  output logic SDA_OE,
  output logic SCL_OE,
  output logic [DATA_WIDTH-1:0] DATA_R,
  output logic DATA_R_VLD,
  output logic DATA_W_REQ,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  input  logic DATA_W_VLD,
  output logic BUSY,
  output logic RD_UNDERRUN
);
`ifdef I2C_TARGET_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  localparam logic [3:0] LAST = 4'(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_q, r_sda_q, r_rise, r_fall, r_start, r_stop;
  logic w_scl, w_sda, w_load;
  state_t r_state, n_state;
  logic [3:0] r_cnt, n_cnt;
  logic [DATA_WIDTH-1:0] r_shift, n_shift, r_tx, n_tx, r_wbyte, n_wbyte, r_data_r, n_data_r;
  logic r_have, n_have, r_req, n_req, r_sda_oe, n_sda_oe, r_scl_oe, n_scl_oe;
  logic r_busy, n_busy, r_pend, n_pend, r_vld, r_under, n_under;
  logic [1:0] r_setup, n_setup;
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_start <= 1'b0;
      r_stop <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL_IN};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDA_IN};
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
      r_rise <= w_scl & ~r_scl_q;
      r_fall <= ~w_scl & r_scl_q;
      r_start <= w_scl & r_scl_q & ~w_sda & r_sda_q;
      r_stop <= w_scl & r_scl_q & w_sda & ~r_sda_q;
    end
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_shift <= '0;
      r_tx <= '0;
      r_wbyte <= '0;
      r_data_r <= '0;
      r_have <= 1'b0;
      r_req <= 1'b0;
      r_sda_oe <= 1'b0;
      r_scl_oe <= 1'b0;
      r_busy <= 1'b0;
      r_pend <= 1'b0;
      r_vld <= 1'b0;
      r_under <= 1'b0;
      r_setup <= '0;
    end else begin
      r_state <= n_state;
      r_cnt <= n_cnt;
      r_shift <= n_shift;
      r_tx <= n_tx;
      r_wbyte <= n_wbyte;
      r_data_r <= n_data_r;
      r_have <= n_have;
      r_req <= n_req;
      r_sda_oe <= n_sda_oe;
      r_scl_oe <= n_scl_oe;
      r_busy <= n_busy;
      r_pend <= n_pend;
      r_vld <= r_pend;
      r_under <= n_under;
      r_setup <= n_setup;
    end
  end
  // The MSB of a read byte is loaded on the falling edge that ends an ACK slot.
  assign w_load = r_fall & ((r_state == ADDR_ACK & r_shift[0]) | (r_state == RD_DATA & r_cnt == 4'd0));
  always_comb begin
    n_state = r_state;
    n_cnt = r_cnt;
    n_shift = r_shift;
    n_tx = r_tx;
    n_wbyte = r_wbyte;
    n_data_r = r_data_r;
    n_have = r_have;
    n_req = r_req;
    n_sda_oe = r_sda_oe;
    n_scl_oe = r_scl_oe;
    n_busy = r_busy;
    n_pend = 1'b0;
    n_under = 1'b0;
    n_setup = r_setup;
    if (r_req && DATA_W_VLD) begin
      n_wbyte = DATA_W;
      n_have = 1'b1;
      n_req = 1'b0;
    end
    if (r_stop || r_start) begin
      n_state = r_stop ? IDLE : ADDR;
      n_cnt = '0;
      n_sda_oe = 1'b0;
      n_scl_oe = 1'b0;
      n_busy = r_stop ? 1'b0 : r_busy;
      n_req = 1'b0;
      n_have = 1'b0;
      n_setup = '0;
    end else if (STRETCH && r_scl_oe) begin
      // SCL is held low; once data arrives drive the MSB, then give it setup time before releasing.
      if (r_setup != 2'd0) begin
        n_setup = r_setup - 2'd1;
        n_scl_oe = r_setup != 2'd1;
      end else if (r_have) begin
        n_tx = r_wbyte;
        n_have = 1'b0;
        n_sda_oe = ~r_wbyte[DATA_WIDTH-1];
        n_cnt = 4'd1;
        n_setup = 2'd2;
      end
    end else if (w_load) begin
      n_state = RD_DATA;
      if (r_have) begin
        n_tx = r_wbyte;
        n_have = 1'b0;
        n_sda_oe = ~r_wbyte[DATA_WIDTH-1];
        n_cnt = 4'd1;
      end else if (STRETCH) begin
        n_scl_oe = 1'b1;
        n_sda_oe = 1'b0;
        n_cnt = 4'd0;
      end else begin
        n_tx = '1;
        n_sda_oe = 1'b0;
        n_under = 1'b1;
        n_cnt = 4'd1;
      end
    end else begin
      case (r_state)
        ADDR, WR_DATA: begin
          if (r_rise) begin
            n_shift = {r_shift[DATA_WIDTH-2:0], r_sda_q};
            n_cnt = r_cnt + 4'd1;
            n_data_r = (r_state == WR_DATA && r_cnt == LAST - 4'd1) ? {r_shift[DATA_WIDTH-2:0], r_sda_q} : r_data_r;
            n_pend = r_state == WR_DATA && r_cnt == LAST - 4'd1;
          end else if (r_fall && r_cnt == LAST) begin
            n_sda_oe = r_state == WR_DATA || r_shift[DATA_WIDTH-1:1] == TARGET_ADDR;
            n_state = r_state == WR_DATA ? WR_ACK : (r_shift[DATA_WIDTH-1:1] == TARGET_ADDR ? ADDR_ACK : IGNORE);
            n_busy = r_busy || (r_state == ADDR && r_shift[DATA_WIDTH-1:1] == TARGET_ADDR);
          end
        end
        ADDR_ACK: begin
          n_req = (r_rise && r_shift[0]) ? 1'b1 : n_req;
          if (r_fall) begin
            n_sda_oe = 1'b0;
            n_cnt = '0;
            n_state = WR_DATA;
          end
        end
        WR_ACK: begin
          if (r_fall) begin
            n_sda_oe = 1'b0;
            n_cnt = '0;
            n_state = WR_DATA;
          end
        end
        RD_DATA: begin
          if (r_fall) begin
            n_state = r_cnt == LAST ? RD_ACK : RD_DATA;
            n_sda_oe = r_cnt == LAST ? 1'b0 : ~r_tx[DATA_WIDTH-2];
            n_tx = r_cnt == LAST ? r_tx : {r_tx[DATA_WIDTH-2:0], 1'b1};
            n_cnt = r_cnt == LAST ? r_cnt : r_cnt + 4'd1;
          end
        end
        RD_ACK: begin
          if (r_rise) begin
            n_state = r_sda_q ? IGNORE : RD_DATA;
            n_req = ~r_sda_q;
            n_have = r_sda_q ? 1'b0 : n_have;
            n_cnt = '0;
          end
        end
        default: ;
      endcase
    end
  end
  assign SDA_OE = r_sda_oe;
  assign SCL_OE = STRETCH & r_scl_oe;
  assign DATA_R = r_data_r;
  assign DATA_R_VLD = r_vld;
  assign DATA_W_REQ = r_req;
  assign BUSY = r_busy;
  assign RD_UNDERRUN = r_under;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: open-drain bus master model, random transfers, scoreboard of expected bytes and acks.
module tb_i2c_target;
  localparam logic [6:0] TADDR = 7'h50;
  localparam int Q = 5;
  logic PCLK = 0, PRESETn = 0, m_scl_low = 0, m_sda_low = 0;
  logic w_scl, w_sda, SDA_OE, SCL_OE, DATA_R_VLD, DATA_W_REQ, BUSY, RD_UNDERRUN;
  logic DATA_W_VLD = 0, user_en = 1;
  logic [7:0] DATA_R, DATA_W = 0;
  int n_chk = 0, n_err = 0, under_cnt = 0, req_rise = 0, oe_cnt = 0, scl_cnt = 0;
  logic req_prev = 0;
  logic [7:0] vld_log[$];
  logic [7:0] rd_q[$];
  assign w_scl = ~(m_scl_low | SCL_OE);
  assign w_sda = ~(m_sda_low | SDA_OE);
  always #5 PCLK = ~PCLK;
  i2c_target dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .SCL_IN(w_scl), .SDA_IN(w_sda),
    .SDA_OE(SDA_OE), .SCL_OE(SCL_OE), .DATA_R(DATA_R), .DATA_R_VLD(DATA_R_VLD),
    .DATA_W_REQ(DATA_W_REQ), .DATA_W(DATA_W), .DATA_W_VLD(DATA_W_VLD),
    .BUSY(BUSY), .RD_UNDERRUN(RD_UNDERRUN)
  );
  always @(negedge PCLK) begin
    if (DATA_R_VLD) vld_log.push_back(DATA_R);
    if (RD_UNDERRUN) under_cnt++;
    if (DATA_W_REQ && !req_prev) req_rise++;
    if (SDA_OE) oe_cnt++;
    if (SCL_OE) scl_cnt++;
    req_prev = DATA_W_REQ;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_q();
    repeat (Q) @(negedge PCLK);
  endtask
  task automatic bus_bit(input logic b, output logic r);
    int i;
    m_sda_low = ~b;
    wait_q();
    m_scl_low = 0;
    for (i = 0; i < 4000 && !w_scl; i++) @(negedge PCLK);
    if (!w_scl) check("scl_release_timeout", w_scl, 1);
    wait_q();
    r = w_sda;
    wait_q();
    m_scl_low = 1;
    wait_q();
  endtask
  task automatic bus_start();
    m_sda_low = 0;
    wait_q();
    m_scl_low = 0;
    wait_q();
    m_sda_low = 1;
    wait_q();
    m_scl_low = 1;
    wait_q();
  endtask
  task automatic bus_stop();
    m_sda_low = 1;
    wait_q();
    m_scl_low = 0;
    wait_q();
    m_sda_low = 0;
    wait_q();
    wait_q();
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    d = 0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, r);
      d = {d[6:0], r};
    end
    bus_bit(nack, r);
  endtask
  initial begin
    logic ack, r;
    logic [7:0] got, ab;
    logic [6:0] a;
    logic [7:0] exp_b[4];
    int n, v0, o0, r0, u0, s0;
    fork
      forever begin
        @(negedge PCLK);
        if (DATA_W_REQ && user_en && rd_q.size() != 0 && !DATA_W_VLD) begin
          DATA_W = rd_q.pop_front();
          DATA_W_VLD = 1;
        end else DATA_W_VLD = 0;
      end
    join_none
    repeat (4) @(negedge PCLK);
    check("rst_sda_oe", SDA_OE, 0);
    check("rst_scl_oe", SCL_OE, 0);
    check("rst_data_r", DATA_R, 0);
    check("rst_data_r_vld", DATA_R_VLD, 0);
    check("rst_req", DATA_W_REQ, 0);
    check("rst_busy", BUSY, 0);
    check("rst_underrun", RD_UNDERRUN, 0);
    PRESETn = 1;
    repeat (4) @(negedge PCLK);
    // directed write of two bytes
    v0 = vld_log.size();
    bus_start();
    write_byte(8'hA0, ack); check("t1_addr_ack", ack, 1);
    write_byte(8'h3C, ack); check("t1_ack0", ack, 1);
    write_byte(8'hC3, ack); check("t1_ack1", ack, 1);
    check("t1_busy", BUSY, 1);
    bus_stop();
    repeat (5) @(negedge PCLK);
    check("t1_busy_after", BUSY, 0);
    check("t1_vld_count", vld_log.size() - v0, 2);
    if (vld_log.size() - v0 == 2) begin
      check("t1_byte0", vld_log[v0], 8'h3C);
      check("t1_byte1", vld_log[v0+1], 8'hC3);
    end
    // wrong address
    v0 = vld_log.size(); o0 = oe_cnt;
    bus_start();
    write_byte(8'hA2, ack); check("t2_nack", ack, 0);
    write_byte(8'h12, ack); check("t2_data_nack", ack, 0);
    bus_stop();
    check("t2_no_oe", oe_cnt - o0, 0);
    check("t2_no_vld", vld_log.size() - v0, 0);
    check("t2_busy", BUSY, 0);
    // random writes
    for (int t = 0; t < 6; t++) begin
      a = $urandom_range(0, 1) ? TADDR : 7'($urandom_range(0, 127));
      n = $urandom_range(1, 4);
      v0 = vld_log.size(); o0 = oe_cnt;
      bus_start();
      write_byte({a, 1'b0}, ack); check("rw_addr_ack", ack, a == TADDR);
      if (a == TADDR)
        for (int i = 0; i < n; i++) begin
          exp_b[i] = 8'($urandom);
          write_byte(exp_b[i], ack); check("rw_data_ack", ack, 1);
        end
      bus_stop();
      if (a == TADDR) begin
        check("rw_vld_count", vld_log.size() - v0, n);
        for (int i = 0; i < n && v0 + i < vld_log.size(); i++) check("rw_byte", vld_log[v0+i], exp_b[i]);
      end else begin
        check("rw_no_vld", vld_log.size() - v0, 0);
        check("rw_no_oe", oe_cnt - o0, 0);
      end
    end
    // directed read: ACK then NACK, then bus ignored
    rd_q.push_back(8'h5A); rd_q.push_back(8'h96);
    r0 = req_rise;
    bus_start();
    write_byte(8'hA1, ack); check("t3_addr_ack", ack, 1);
    read_byte(1'b0, got); check("t3_byte0", got, 8'h5A);
    read_byte(1'b1, got); check("t3_byte1", got, 8'h96);
    check("t3_req_rises", req_rise - r0, 2);
    check("t3_req_low", DATA_W_REQ, 0);
    o0 = oe_cnt;
    read_byte(1'b1, got); check("t3_ignored", got, 8'hFF);
    check("t3_ignore_oe", oe_cnt - o0, 0);
    bus_stop();
    // random reads
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        exp_b[i] = 8'($urandom);
        rd_q.push_back(exp_b[i]);
      end
      r0 = req_rise;
      bus_start();
      write_byte({TADDR, 1'b1}, ack); check("rr_addr_ack", ack, 1);
      for (int i = 0; i < n; i++) begin
        read_byte(i == n - 1, got); check("rr_byte", got, exp_b[i]);
      end
      bus_stop();
      check("rr_req_rises", req_rise - r0, n);
      check("rr_req_low", DATA_W_REQ, 0);
    end
    // write then repeated START into a read
    rd_q.push_back(8'h77);
    bus_start();
    write_byte(8'hA0, ack); check("t4_waddr_ack", ack, 1);
    write_byte(8'h11, ack); check("t4_wdata_ack", ack, 1);
    bus_start();
    write_byte(8'hA1, ack); check("t4_raddr_ack", ack, 1);
    read_byte(1'b1, got); check("t4_rdata", got, 8'h77);
    check("t4_data_r", DATA_R, 8'h11);
    bus_stop();
    // missing read data
    u0 = under_cnt; s0 = scl_cnt;
    user_en = 0;
`ifdef I2C_TARGET_STRETCH_EN
    rd_q.push_back(8'h33);
    fork
      begin
        repeat (300) @(negedge PCLK);
        user_en = 1;
      end
    join_none
    bus_start();
    write_byte(8'hA1, ack); check("t5_addr_ack", ack, 1);
    read_byte(1'b1, got); check("t5_stretch_data", got, 8'h33);
    check("t5_stretched", scl_cnt > s0 + 100, 1);
    check("t5_no_underrun", under_cnt - u0, 0);
`else
    bus_start();
    write_byte(8'hA1, ack); check("t5_addr_ack", ack, 1);
    read_byte(1'b1, got); check("t5_underrun_data", got, 8'hFF);
    check("t5_underrun_pulses", under_cnt - u0, 1);
    check("t5_no_stretch", scl_cnt - s0, 0);
`endif
    bus_stop();
    user_en = 1;
    // reset while the target is pulling SDA for the address ACK
    bus_start();
    ab = 8'hA0;
    for (int i = 7; i >= 0; i--) bus_bit(ab[i], r);
    check("t6_oe_before", SDA_OE, 1);
    @(negedge PCLK);
    PRESETn = 0;
    #1;
    check("t6_oe_async", SDA_OE, 0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1;
    v0 = vld_log.size(); o0 = oe_cnt;
    bus_bit(1'b1, r);
    write_byte(8'h55, ack); check("t6_ignored_ack", ack, 0);
    check("t6_no_oe", oe_cnt - o0, 0);
    check("t6_no_vld", vld_log.size() - v0, 0);
    bus_start();
    write_byte(8'hA0, ack); check("t6_addr_ack", ack, 1);
    write_byte(8'h66, ack); check("t6_data_ack", ack, 1);
    bus_stop();
    check("t6_vld_count", vld_log.size() - v0, 1);
    check("t6_data_r", DATA_R, 8'h66);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
Synthesizable I2C target (slave) that responds to the I2C master in the `i2c` block over the shared SCL/SDA bus. It oversamples both lines on PCLK and matches a fixed 7-bit address. For master writes it ACKs and delivers each received byte on a valid pulse. For master reads it fetches bytes through a request/valid handshake and shifts them out MSB-first.

Parameters:
DATA_WIDTH, 8, data byte width; only 8 is supported.
TARGET_ADDR, 7'h50, 7-bit address this target responds to.
SYNC_STAGES, 2, flops in the SCL_IN/SDA_IN synchronizers; minimum 2.

Ports:
PCLK  input  1  system clock; must run at least 8x the SCL rate.
PRESETn  input  1  asynchronous active-low reset.
SCL_IN  input  1  bus SCL level (pad input).
SDA_IN  input  1  bus SDA level (pad input).
SDA_OE  output  1  1 = pull SDA low; 0 = release.
SCL_OE  output  1  1 = pull SCL low (clock stretch); tied 0 when the optional feature is compiled out.
DATA_R  output  DATA_WIDTH  last byte received from the master.
DATA_R_VLD  output  1  one-PCLK pulse when DATA_R is updated.
DATA_W_REQ  output  1  level; high while a read byte is requested.
DATA_W  input  DATA_WIDTH  read byte from the user.
DATA_W_VLD  input  1  user qualifier; byte accepted when high while DATA_W_REQ is high.
BUSY  output  1  high from an address-matched START until STOP.
RD_UNDERRUN  output  1  one-PCLK pulse when read data was missing at shift-out.

Behaviour:
- Reset values: SDA_OE=0, SCL_OE=0, DATA_R=0, DATA_R_VLD=0, DATA_W_REQ=0, BUSY=0, RD_UNDERRUN=0; state IDLE.
- Reset mid-transfer releases both lines at once. The block ignores the bus until the next START.
- Synchronized SCL/SDA feed registered edge detectors, so all events occur SYNC_STAGES+1 PCLK cycles after the pad change.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both take priority over bit processing in every state.
- Sampling: data is sampled on detected SCL rising edges. SDA_OE changes only on detected SCL falling edges.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- START in any state: clear the bit counter and go to ADDR. A repeated START is treated identically.
- STOP in any state: go to IDLE, release SDA_OE, clear BUSY and DATA_W_REQ.
- ADDR: shift 8 bits.
  - Bits[7:1]==TARGET_ADDR: on the 8th falling edge assert SDA_OE, set BUSY, go to ADDR_ACK.
  - Mismatch: go to IGNORE with SDA released, so the master sees NACK.
- ADDR_ACK, 9th-bit falling edge:
  - R/W=0: release SDA and go to WR_DATA.
  - R/W=1: go to RD_DATA and drive the MSB of the loaded byte.
  - DATA_W_REQ rises on the 9th rising edge of the address phase.
- WR_DATA: shift 8 bits. On the 8th rising edge, DATA_R is updated and DATA_R_VLD pulses 1 cycle later. On the 8th falling edge assert SDA_OE and go to WR_ACK. The block ACKs every write byte.
- WR_ACK: on the falling edge, release SDA and return to WR_DATA.
- Read handshake:
  - A byte is latched when DATA_W_VLD=1 and DATA_W_REQ=1, and DATA_W_REQ drops on the next cycle.
  - DATA_W_REQ re-rises on the SCL rising edge of each master ACK.
- Missing read data at shift-out time (feature compiled out): send 8'hFF (SDA released) and pulse RD_UNDERRUN.
- RD_DATA: on each falling edge drive SDA_OE = ~bit, MSB first. After the 8th bit's falling edge release SDA and go to RD_ACK.
- RD_ACK: sample SDA on the rising edge.
  - 0 (ACK): stay in the read sequence; the next falling edge drives the new MSB in RD_DATA.
  - 1 (NACK): go to IGNORE, clear DATA_W_REQ and drop any pending byte.
- IGNORE: SDA released; wait only for START or STOP.

Optional Feature:
Macro I2C_TARGET_STRETCH_EN.
- Defined: if no read byte is latched at the falling edge where the MSB must be driven, assert SCL_OE and hold it. After DATA_W_VLD, drive the MSB, wait 2 PCLK of setup, then release SCL_OE. RD_UNDERRUN never pulses.
- Undefined: SCL_OE is constant 0 and underrun behaviour is as in Behaviour.

Test Plan:
1. START, 0xA0, 0x3C, 0xC3, STOP -> target ACKs all 3 bytes; DATA_R_VLD pulses twice with 0x3C then 0xC3; BUSY high START to STOP, 0 afterwards.
2. START, 0xA2 (addr 0x51) -> no ACK; SDA_OE never asserts; no DATA_R_VLD until the next START.
3. START, 0xA1, user answers the request with 0x5A then 0x96; master ACKs the first byte, NACKs the second -> SDA shows 01011010, 10010110; DATA_W_REQ rises twice; IGNORE after NACK.
4. Write 0xA0 + 0x11, then repeated START with 0xA1 and no STOP, user supplies 0x77 -> DATA_R=0x11, then SDA shows 0x77.
5. Read with DATA_W_VLD held low: macro off -> byte reads 0xFF and RD_UNDERRUN pulses once; macro on -> SCL held low until DATA_W_VLD with 0x33, then 0x33 is shifted out.
6. PRESETn asserted mid-byte while SDA_OE=1 -> SDA_OE=0 immediately; subsequent bits are ignored until a new START, then normal ACK.
